// File: rtl/dw_weight_cache_pkg.sv
// Shared definitions for the depthwise weight cache: FSM encoding and the
// beat/count widths it must agree on with the weight loader arbiter.
package dw_weight_cache_pkg;

  localparam int DW_DATA_W = 128;
  localparam int DW_CNT_W  = 17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2
  } dw_state_e;

endpackage

// File: rtl/dw_wbank_ram.sv
// One weight bank: DEPTH x DATA_W simple dual-port RAM with a single write
// port and a registered read port whose output holds between reads.
module dw_wbank_ram
  import dw_weight_cache_pkg::*;
#(
  parameter  int DATA_W = DW_DATA_W,
  parameter  int DEPTH  = 512,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read stage: output register clears on reset, storage does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dw_weight_cache.sv
// Ping-pong weight store for the depthwise engine: one bank is filled from the
// arbiter's DW port while the other bank is served to the compute array.
module dw_weight_cache
  import dw_weight_cache_pkg::*;
#(
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = DW_DATA_W,
  parameter  int DEPTH  = 512,
  parameter  int CNT_W  = DW_CNT_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int PTR_W  = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [CNT_W-1:0]  fill_count,
  output logic              fill_ready,
  output logic              dw_req,
  output logic [ADDR_W-1:0] dw_base,
  output logic [CNT_W-1:0]  dw_count,
  input  logic              dw_grant,
  input  logic              dw_valid,
  input  logic [DATA_W-1:0] dw_data,
  input  logic              dw_done,
  output logic [1:0]        bank_ready,
  output logic              cons_sel,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              cons_release,
  output logic              err_ovf,
  output logic              err_short
);

  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

  dw_state_e         state_q, state_d;
  logic              fill_sel;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  cnt_final;
  logic              fill_accept, fill_done, beat_in, beat_wr, beat_ovf;
  logic              rel_ok;
  logic [1:0]        bank_ready_d;
  logic              rd_vld_p1, rd_sel_p1;
  logic [DATA_W-1:0] rdata0_p1, rdata1_p1;

  assign fill_ready = (state_q == S_IDLE) && !bank_ready[fill_sel];
  assign dw_req     = (state_q == S_REQ);
  assign beat_in    = (state_q == S_FILL) && dw_valid;
  // A beat arriving together with dw_done still counts toward the short check.
  assign cnt_final  = beat_cnt + {{(CNT_W-1){1'b0}}, beat_in};
  assign rel_ok     = cons_release && bank_ready[cons_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_accept = 1'b0;
    fill_done   = 1'b0;
    beat_wr     = 1'b0;
    beat_ovf    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fill_start && fill_ready && (fill_count != '0)) begin
          fill_accept = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (dw_grant) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        beat_wr  = dw_valid && (wr_ptr != PTR_FULL);
        beat_ovf = dw_valid && (wr_ptr == PTR_FULL);
        if (dw_done) begin
          fill_done = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Release and fill completion always hit different banks, so both may apply.
  always_comb begin
    bank_ready_d = bank_ready;
    if (rel_ok) begin
      bank_ready_d[cons_sel] = 1'b0;
    end
    if (fill_done) begin
      bank_ready_d[fill_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_sel   <= 1'b0;
      cons_sel   <= 1'b0;
      bank_ready <= 2'b00;
      wr_ptr     <= '0;
      beat_cnt   <= '0;
      dw_base    <= '0;
      dw_count   <= '0;
      err_ovf    <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      bank_ready <= bank_ready_d;
      if (fill_accept) begin
        dw_base  <= fill_base;
        dw_count <= fill_count;
        wr_ptr   <= '0;
        beat_cnt <= '0;
      end
      if (beat_in) begin
        beat_cnt <= cnt_final;
      end
      if (beat_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (beat_ovf) begin
        err_ovf <= 1'b1;
      end
      if (fill_done) begin
        fill_sel <= ~fill_sel;
        if (cnt_final < dw_count) begin
          err_short <= 1'b1;
        end
      end
      if (rel_ok) begin
        cons_sel <= ~cons_sel;
      end
    end
  end

  dw_wbank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (beat_wr && !fill_sel),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (dw_data),
    .re    (rd_en && !cons_sel),
    .raddr (rd_addr),
    .rdata (rdata0_p1)
  );

  dw_wbank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (beat_wr && fill_sel),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (dw_data),
    .re    (rd_en && cons_sel),
    .raddr (rd_addr),
    .rdata (rdata1_p1)
  );

  // Read stage p1: the output bank select only moves on a read, so rd_data
  // holds across idle cycles and across a consumer bank swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_p1 <= 1'b0;
      rd_sel_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_en && bank_ready[cons_sel];
      if (rd_en) begin
        rd_sel_p1 <= cons_sel;
      end
    end
  end

  assign rd_data  = rd_sel_p1 ? rdata1_p1 : rdata0_p1;
  assign rd_valid = rd_vld_p1;

endmodule

// File: tb/tb_dw_weight_cache.sv
// Scoreboard bench for dw_weight_cache: an arbiter model drives fills, reads are
// predicted from per-bank beat lists and checked by an independent monitor.
module tb_dw_weight_cache;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 17;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fill_start = 1'b0;
  logic [ADDR_W-1:0] fill_base = '0;
  logic [CNT_W-1:0]  fill_count = '0;
  logic              fill_ready;
  logic              dw_req;
  logic [ADDR_W-1:0] dw_base;
  logic [CNT_W-1:0]  dw_count;
  logic              dw_grant = 1'b0;
  logic              dw_valid = 1'b0;
  logic [DATA_W-1:0] dw_data = '0;
  logic              dw_done = 1'b0;
  logic [1:0]        bank_ready;
  logic              cons_sel;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              cons_release = 1'b0;
  logic              err_ovf;
  logic              err_short;

  dw_weight_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fill_start(fill_start), .fill_base(fill_base),
    .fill_count(fill_count), .fill_ready(fill_ready), .dw_req(dw_req),
    .dw_base(dw_base), .dw_count(dw_count), .dw_grant(dw_grant),
    .dw_valid(dw_valid), .dw_data(dw_data), .dw_done(dw_done),
    .bank_ready(bank_ready), .cons_sel(cons_sel), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .cons_release(cons_release), .err_ovf(err_ovf), .err_short(err_short)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: what each bank holds and who owns which bank.
  logic [DATA_W-1:0] mdl_mem [2][DEPTH];
  int  mdl_len [2];
  bit  mdl_ready [2];
  bit  mdl_cons, mdl_fill, mdl_ovf, mdl_short;

  typedef struct {
    int                issue;
    bit                vld;
    bit                chkdata;
    logic [DATA_W-1:0] data;
    int                addr;
  } rd_exp_t;
  rd_exp_t sb[$];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] mdl_bank_ready();
    return {mdl_ready[1], mdl_ready[0]};
  endfunction

  function automatic bit mdl_fill_ready();
    return !mdl_ready[mdl_fill];
  endfunction

  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (sb.size() != 0 && sb[0].issue < cyc) begin
      e = sb.pop_front();
      checks++;
      if (rd_valid !== e.vld) begin
        failures++;
        $display("FAIL rd_valid addr=%0d: got %0b expected %0b", e.addr, rd_valid, e.vld);
      end
      if (e.chkdata) begin
        checks++;
        if (rd_data !== e.data) begin
          failures++;
          $display("FAIL rd_data addr=%0d: got %0h expected %0h", e.addr, rd_data, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_burst(input int n, input bit seq);
    rd_exp_t e;
    bit have_last = 0;
    logic [DATA_W-1:0] last = '0;
    for (int i = 0; i < n; i++) begin
      step();
      e.addr    = seq ? (i % DEPTH) : int'($urandom_range(0, DEPTH - 1));
      e.issue   = cyc;
      e.vld     = mdl_ready[mdl_cons];
      e.chkdata = e.vld && (e.addr < mdl_len[mdl_cons]);
      e.data    = e.chkdata ? mdl_mem[mdl_cons][e.addr] : '0;
      rd_en     = 1'b1;
      rd_addr   = AW'(e.addr);
      sb.push_back(e);
      have_last = e.chkdata;
      last      = e.data;
    end
    step();
    rd_en = 1'b0;
    repeat (3) step();
    if (have_last) chk("rd_data_hold", rd_data, last);
  endtask

  task automatic do_release();
    step();
    cons_release = 1'b1;
    step();
    cons_release = 1'b0;
    if (mdl_ready[mdl_cons]) begin
      mdl_ready[mdl_cons] = 0;
      mdl_len[mdl_cons]   = 0;
      mdl_cons            = ~mdl_cons;
    end
    chk("cons_sel", cons_sel, mdl_cons);
    chk("bank_ready_rel", bank_ready, mdl_bank_ready());
  endtask

  task automatic start_and_grant(input logic [ADDR_W-1:0] base, input int count,
                                 input int gdly, output bit ok);
    ok = 0;
    step();
    fill_start = 1'b1;
    fill_base  = base;
    fill_count = CNT_W'(count);
    step();
    fill_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dw_req) begin
        ok = 1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL dw_req_timeout: got 0 expected 1");
      return;
    end
    chk("dw_base", dw_base, base);
    chk("dw_count", dw_count, CNT_W'(count));
    repeat (gdly) step();
    dw_grant = 1'b1;
    step();
    dw_grant = 1'b0;
    chk("dw_req_drop", dw_req, 1'b0);
  endtask

  task automatic do_fill(input logic [ADDR_W-1:0] base, input int count, input int nbeats,
                         input bit same_done, input int gdly, input bit fixed,
                         input logic [DATA_W-1:0] d0);
    logic [DATA_W-1:0] beats [$];
    logic [DATA_W-1:0] d;
    bit ok;
    start_and_grant(base, count, gdly, ok);
    if (!ok) return;
    for (int b = 0; b < nbeats; b++) begin
      if (!fixed && $urandom_range(0, 3) == 0) step();
      d = fixed ? d0 + DATA_W'(b) : {$urandom, $urandom, $urandom, $urandom};
      beats.push_back(d);
      dw_valid = 1'b1;
      dw_data  = d;
      if (same_done && b == nbeats - 1) dw_done = 1'b1;
      step();
      dw_valid = 1'b0;
      dw_done  = 1'b0;
    end
    if (!same_done) begin
      dw_done = 1'b1;
      step();
      dw_done = 1'b0;
    end
    mdl_len[mdl_fill] = (nbeats > DEPTH) ? DEPTH : nbeats;
    for (int i = 0; i < mdl_len[mdl_fill]; i++) mdl_mem[mdl_fill][i] = beats[i];
    if (nbeats > DEPTH) mdl_ovf = 1;
    if (nbeats < count) mdl_short = 1;
    mdl_ready[mdl_fill] = 1;
    mdl_fill = ~mdl_fill;
    chk("bank_ready_fill", bank_ready, mdl_bank_ready());
    chk("fill_ready", fill_ready, mdl_fill_ready());
    chk("err_ovf", err_ovf, mdl_ovf);
    chk("err_short", err_short, mdl_short);
  endtask

  task automatic check_reset_outputs();
    chk("rst_dw_req", dw_req, 1'b0);
    chk("rst_dw_base", dw_base, '0);
    chk("rst_dw_count", dw_count, '0);
    chk("rst_bank_ready", bank_ready, 2'b00);
    chk("rst_cons_sel", cons_sel, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_err_ovf", err_ovf, 1'b0);
    chk("rst_err_short", err_short, 1'b0);
    chk("rst_fill_ready", fill_ready, 1'b1);
  endtask

  task automatic mdl_reset();
    mdl_ready[0] = 0; mdl_ready[1] = 0;
    mdl_len[0] = 0;   mdl_len[1] = 0;
    mdl_cons = 0; mdl_fill = 0; mdl_ovf = 0; mdl_short = 0;
  endtask

  task automatic expect_no_req(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk(name, dw_req, 1'b0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    mdl_reset();
    repeat (3) step();
    check_reset_outputs();
    rst = 1'b0;

    // Basic fill into bank 0, then read it back.
    do_fill(16'h0100, 4, 4, 0, 2, 1, 128'hA0);
    read_burst(4, 1);

    // Prefetch bank 1 while bank 0 is continuously read.
    fork
      read_burst(30, 0);
      do_fill(16'h0200, 3, 3, 0, 1, 0, '0);
    join
    step();
    fill_start = 1'b1; fill_base = 16'h0300; fill_count = CNT_W'(5);
    step();
    fill_start = 1'b0;
    expect_no_req("dw_req_both_full", 5);
    chk("bank_ready_both", bank_ready, 2'b11);

    // Release and reuse bank 0.
    do_release();
    read_burst(6, 0);
    do_fill(16'h0300, 2, 2, 0, 0, 0, '0);

    // Final beat coincides with dw_done.
    do_release();
    do_fill(16'h0400, 4, 4, 1, 1, 1, 128'hB0);
    do_release();
    read_burst(4, 1);

    // Short load, then overflow load.
    do_fill(16'h0500, 5, 3, 0, 1, 0, '0);
    do_release();
    do_fill(16'h0600, DEPTH + 2, DEPTH + 2, 0, 1, 0, '0);
    do_release();
    read_burst(DEPTH, 1);

    // Randomised rounds.
    for (int r = 0; r < 3; r++) begin
      int cnt;
      cnt = int'($urandom_range(1, DEPTH));
      do_release();
      if (!mdl_ready[mdl_fill])
        do_fill(ADDR_W'($urandom), cnt, cnt, bit'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), 0, '0);
      read_burst(8, 0);
    end

    // Drain both banks; extra release is ignored and reads are not valid.
    do_release();
    do_release();
    do_release();
    read_burst(4, 0);

    // Reset in the middle of a fill.
    start_and_grant(16'h0700, 6, 1, ok);
    for (int b = 0; b < 2; b++) begin
      dw_valid = 1'b1;
      dw_data  = {4{$urandom}};
      step();
    end
    dw_valid = 1'b0;
    rst = 1'b1;
    step();
    mdl_reset();
    check_reset_outputs();
    rst = 1'b0;
    repeat (4) step();

    // Zero-count fill is ignored.
    step();
    fill_start = 1'b1; fill_base = 16'h0800; fill_count = '0;
    step();
    fill_start = 1'b0;
    expect_no_req("dw_req_zero_cnt", 5);

    // Recovery after reset.
    do_fill(16'h0900, 3, 3, 0, 2, 0, '0);
    read_burst(3, 1);

    repeat (3) step();
    chk("scoreboard_drained", DATA_W'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
